qracc_bitserial_accumulator: RTL
================================

QRACC_BITSERIAL_ACCUMULATOR -- requirements
Module: qracc_bitserial_accumulator

Interface
REQ-001 Parameters SHALL be: numCols, default 32, number of array columns; numAdcBits, default 4, ADC code width; maxInBits, default 8, maximum activation bit-planes; accBits, default 16, signed accumulator width.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle request to begin a new accumulation job.
REQ-005 num_bits_i  input  $clog2(maxInBits+1)  bit-planes in the job, sampled on an accepted start.
REQ-006 signed_i  input  1  1 = two's-complement activations (first plane is the MSB and carries negative weight); sampled on an accepted start.
REQ-007 adc_valid_i  input  1  one-cycle strobe: adc_data_i holds one bit-plane result.
REQ-008 adc_data_i  input  numCols x numAdcBits  per-column signed ADC codes, range -8..7 at the default width.
REQ-009 busy_o  output  1  high from the accepted start until the result is accepted.
REQ-010 plane_req_o  output  1  high in ACCUM while more planes are expected.
REQ-011 result_valid_o  output  1  result_o is valid.
REQ-012 result_ready_i  input  1  downstream accepts result_o.
REQ-013 result_o  output  numCols x accBits  per-column signed accumulated sums.
REQ-014 overflow_o  output  1  sticky per job; set if any column saturated.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE, start_i SHALL be accepted, and in the next cycle the block SHALL be in ACCUM with all accumulators, the plane counter and overflow_o cleared.
REQ-017 num_bits_i = 0 SHALL be treated as 1; values above maxInBits SHALL be clamped to maxInBits.
REQ-018 Planes arrive MSB first; on the first adc_valid_i of a job, acc SHALL become -adc when signed_i = 1 and +adc when signed_i = 0, using a sign-extended code.
REQ-019 On each later adc_valid_i, acc SHALL become 2*acc + adc, computed at accBits+2 width and then saturated to the signed accBits range.
REQ-020 A saturating update in any column SHALL set overflow_o, which SHALL hold until the next accepted start.
REQ-021 When the adc_valid_i carrying plane number num_bits is consumed, the FSM SHALL enter DONE in the next cycle with result_valid_o = 1; the latency from the last strobe to valid SHALL be 1 cycle.
REQ-022 In DONE, result_o and overflow_o SHALL be stable while result_valid_o = 1 and result_ready_i = 0.
REQ-023 When result_valid_o and result_ready_i are both 1, the result SHALL be accepted, result_valid_o SHALL fall in the next cycle, and the FSM SHALL return to IDLE.
REQ-024 A start_i in the same cycle as result acceptance SHALL be accepted, and the FSM SHALL go directly to ACCUM.
REQ-025 start_i in ACCUM, or in DONE without acceptance, SHALL be ignored.
REQ-026 adc_valid_i in IDLE or DONE SHALL be ignored and SHALL NOT change any accumulator.
REQ-027 plane_req_o SHALL equal (state == ACCUM); busy_o SHALL equal (state != IDLE).
REQ-028 result_o SHALL show the live accumulator value in all states.

Reset
REQ-029 When nrst = 0, the FSM SHALL go to IDLE at once, and the accumulators, plane counter, result_valid_o, busy_o, plane_req_o and overflow_o SHALL all be 0.
REQ-030 Reset asserted mid-job SHALL abandon the job with no result produced.
REQ-031 After reset, the first valid activity SHALL be a new start_i.

Verification
REQ-032 Signed job: num_bits = 3 with column-0 codes 1, 2, 3 -> after the third strobe plus 1 cycle, result_o[0] = -1*4 + 2*2 + 3 = 3, overflow_o = 0.
REQ-033 Unsigned job: num_bits = 2 with codes -8, 7 on every column -> result_o = -9 on all columns.
REQ-034 Saturation: accBits = 6, unsigned, num_bits = 4, codes 7, 7, 7, 7 -> result_o = 31, overflow_o = 1.
REQ-035 Backpressure: hold result_ready_i = 0 for 5 cycles -> result_o stays stable; start_i and adc_valid_i pulses are ignored; acceptance together with start -> next cycle is ACCUM with cleared accumulators.
REQ-036 Reset: assert nrst = 0 after 2 of 4 planes -> all outputs are 0; a new job of 1 plane with code 5, unsigned -> result_o = 5.
REQ-037 num_bits_i = 0 and num_bits_i = 15 -> the job completes after 1 and after maxInBits strobes respectively.

Source files
------------

// File: rtl/qracc_bitserial_accumulator.sv
// Bit-serial accumulator for QR-ACC column ADC results: MSB-first shift-and-add
// with per-column saturation, a sticky overflow flag and a valid/ready result hand-off.
module qracc_bitserial_accumulator #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int maxInBits  = 8,
    parameter int accBits    = 16
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start_i,
    input  logic [$clog2(maxInBits+1)-1:0]     num_bits_i,
    input  logic                               signed_i,
    input  logic                               adc_valid_i,
    input  logic [numCols-1:0][numAdcBits-1:0] adc_data_i,
    output logic                               busy_o,
    output logic                               plane_req_o,
    output logic                               result_valid_o,
    input  logic                               result_ready_i,
    output logic [numCols-1:0][accBits-1:0]    result_o,
    output logic                               overflow_o
);
    localparam int NB_W   = $clog2(maxInBits+1);
    localparam int WIDE_W = accBits + 2;
    localparam logic signed [WIDE_W-1:0] ACC_MAX = {3'b000, {(accBits-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] ACC_MIN = {3'b111, {(accBits-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic signed [WIDE_W-1:0] sext_adc(input logic [numAdcBits-1:0] code);
        return {{(WIDE_W-numAdcBits){code[numAdcBits-1]}}, code};
    endfunction

    function automatic logic signed [WIDE_W-1:0] sext_acc(input logic [accBits-1:0] a);
        return {{2{a[accBits-1]}}, a};
    endfunction

    function automatic logic sat_hit(input logic signed [WIDE_W-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    function automatic logic [accBits-1:0] sat_clip(input logic signed [WIDE_W-1:0] v);
        logic [accBits-1:0] r;
        if (v > ACC_MAX) begin
            r = ACC_MAX[accBits-1:0];
        end else if (v < ACC_MIN) begin
            r = ACC_MIN[accBits-1:0];
        end else begin
            r = v[accBits-1:0];
        end
        return r;
    endfunction

    // A zero-plane request still consumes one plane; oversize requests stop at maxInBits.
    function automatic logic [NB_W-1:0] clamp_nb(input logic [NB_W-1:0] nb);
        logic [NB_W-1:0] r;
        if (nb == {NB_W{1'b0}}) begin
            r = NB_W'(1);
        end else if (nb > NB_W'(maxInBits)) begin
            r = NB_W'(maxInBits);
        end else begin
            r = nb;
        end
        return r;
    endfunction

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic [numCols-1:0][accBits-1:0] acc_r;
    logic [numCols-1:0][accBits-1:0] acc_upd_s;
    logic signed [WIDE_W-1:0]        wide_s [numCols];
    logic [numCols-1:0]              col_sat_s;
    logic [NB_W-1:0]                 plane_cnt_r;
    logic [NB_W-1:0]                 num_bits_r;
    logic                            signed_r;
    logic                            ovf_r;
    logic                            busy_r;
    logic                            plane_req_r;
    logic                            result_valid_r;
    logic                            start_acc_s;
    logic                            last_plane_s;

    assign last_plane_s = ((plane_cnt_r + NB_W'(1)) == num_bits_r);

    // Next-state selection and start acceptance.
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    start_acc_s = 1'b1;
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (adc_valid_i && last_plane_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                if (result_ready_i && start_i) begin
                    start_acc_s = 1'b1;
                    state_nxt_s = ACCUM;
                end else if (result_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-column shift-and-add; the MSB plane of a signed job enters with negative weight.
    always_comb begin
        for (int c = 0; c < numCols; c++) begin
            if (plane_cnt_r == {NB_W{1'b0}}) begin
                if (signed_r) begin
                    wide_s[c] = -sext_adc(adc_data_i[c]);
                end else begin
                    wide_s[c] = sext_adc(adc_data_i[c]);
                end
            end else begin
                wide_s[c] = (sext_acc(acc_r[c]) <<< 1) + sext_adc(adc_data_i[c]);
            end
            col_sat_s[c] = sat_hit(wide_s[c]);
            acc_upd_s[c] = sat_clip(wide_s[c]);
        end
    end

    // State, job context, accumulators and registered status outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r        <= IDLE;
            acc_r          <= {(numCols*accBits){1'b0}};
            plane_cnt_r    <= {NB_W{1'b0}};
            num_bits_r     <= {NB_W{1'b0}};
            signed_r       <= 1'b0;
            ovf_r          <= 1'b0;
            busy_r         <= 1'b0;
            plane_req_r    <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s != IDLE);
            plane_req_r    <= (state_nxt_s == ACCUM);
            result_valid_r <= (state_nxt_s == DONE);
            if (start_acc_s) begin
                acc_r       <= {(numCols*accBits){1'b0}};
                plane_cnt_r <= {NB_W{1'b0}};
                num_bits_r  <= clamp_nb(num_bits_i);
                signed_r    <= signed_i;
                ovf_r       <= 1'b0;
            end else if ((state_r == ACCUM) && adc_valid_i) begin
                acc_r       <= acc_upd_s;
                plane_cnt_r <= plane_cnt_r + NB_W'(1);
                ovf_r       <= ovf_r | (|col_sat_s);
            end else begin
                acc_r       <= acc_r;
                plane_cnt_r <= plane_cnt_r;
                ovf_r       <= ovf_r;
            end
        end
    end

    assign busy_o         = busy_r;
    assign plane_req_o    = plane_req_r;
    assign result_valid_o = result_valid_r;
    assign result_o       = acc_r;
    assign overflow_o     = ovf_r;

endmodule
